// File: rtl/textlcd_ctrl.sv
// textlcd_ctrl: HD44780-style 8-bit parallel LCD write sequencer.
// Runs the power-up init on its own, then writes one byte per handshake.
module textlcd_ctrl #(
    parameter int CNT_W   = 20,
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EPW   = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    typedef enum logic [2:0] {
        PWRUP,
        INIT_LOAD,
        SETUP,
        EHIGH,
        HOLD,
        WAIT,
        IDLE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] lim;
    logic [1:0]       idx;
    logic [1:0]       idx_n;
    logic             done_n;
    logic             load_init;
    logic             load_req;
    logic             is_clr;
    logic             at_end;
    logic [7:0]       init_byte;

    // Power-up command table, walked in order by idx
    always_comb begin
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end

    // Clear (0x01) and home (0x02/0x03) need the long execution wait
    assign is_clr = !lcd_rs
                 && (lcd_data[7:2] == 6'd0)
                 && (lcd_data != 8'd0);

    // Terminal count of the shared counter for the current state
    always_comb begin
        lim = '0;
        case (state)
            PWRUP: lim = CNT_W'(T_PWRUP - 1);
            SETUP: lim = CNT_W'(T_SETUP - 1);
            EHIGH: lim = CNT_W'(T_EPW - 1);
            HOLD:  lim = CNT_W'(T_HOLD - 1);
            WAIT:  lim = is_clr ? CNT_W'(T_CLR - 1)
                                : CNT_W'(T_CMD - 1);
            default: lim = '0;
        endcase
    end

    assign at_end = (cnt == lim);

    // Next-state, counter and load decisions
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        done_n    = init_done;
        load_init = 1'b0;
        load_req  = 1'b0;
        cnt_n     = cnt + CNT_W'(1);
        case (state)
            PWRUP: begin
                if (at_end) state_n = INIT_LOAD;
            end
            INIT_LOAD: begin
                load_init = 1'b1;
                state_n   = SETUP;
            end
            SETUP: begin
                if (at_end) state_n = EHIGH;
            end
            EHIGH: begin
                if (at_end) state_n = HOLD;
            end
            HOLD: begin
                if (at_end) state_n = WAIT;
            end
            WAIT: begin
                if (at_end) begin
                    if (init_done) begin
                        state_n = IDLE;
                    end else if (idx == 2'd3) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + 2'd1;
                        state_n = INIT_LOAD;
                    end
                end
            end
            IDLE: begin
                if (req_valid) begin
                    load_req = 1'b1;
                    state_n  = SETUP;
                end
            end
            default: state_n = PWRUP;
        endcase
        if (state_n != state || state == IDLE) cnt_n = '0;
    end

    // State, counter and registered LCD pin drivers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= PWRUP;
            cnt       <= '0;
            idx       <= '0;
            init_done <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            init_done <= done_n;
            lcd_e     <= (state_n == EHIGH);
            if (load_init) begin
                lcd_rs   <= 1'b0;
                lcd_data <= init_byte;
            end else if (load_req) begin
                lcd_rs   <= req_rs;
                lcd_data <= req_data;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_textlcd_ctrl.sv
// tb_textlcd_ctrl: directed bench for the LCD write sequencer.
// Vector table for single writes, hand sequences for multi-cycle cases.
module tb_textlcd_ctrl;

    localparam int TP = 10;
    localparam int TS = 1;
    localparam int TE = 3;
    localparam int TH = 1;
    localparam int TC = 5;
    localparam int TK = 20;
    localparam int T_INIT = TP + 4 * (1 + TS + TE + TH) + 3 * TC + TK;
    localparam int T_W  = TS + TE + TH + TC;
    localparam int T_WC = TS + TE + TH + TK;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         width;
        int         rise;
    } pulse_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int rw_err = 0;
    int busy_err = 0;
    int stab_err = 0;
    int early_rdy = 0;

    pulse_t pulses[$];
    pulse_t cur;
    logic   prev_e = 1'b0;
    logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    logic [7:0] b2b [3] = '{8'h48, 8'h49, 8'h21};

    textlcd_ctrl #(
        .CNT_W  (20),
        .T_PWRUP(TP),
        .T_SETUP(TS),
        .T_EPW  (TE),
        .T_HOLD (TH),
        .T_CMD  (TC),
        .T_CLR  (TK)
    ) dut (
        .ACLK     (clk),
        .ARESET   (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs   (req_rs),
        .req_data (req_data),
        .init_done(init_done),
        .busy     (busy),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // E-pulse recorder plus sticky pin invariants
    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_err++;
        if (busy !== ~req_ready) busy_err++;
        if (req_ready && !init_done) early_rdy++;
        if (lcd_e && !prev_e) begin
            cur.rs    = lcd_rs;
            cur.data  = lcd_data;
            cur.width = 1;
            cur.rise  = cyc;
        end else if (lcd_e) begin
            cur.width++;
            if (lcd_rs !== cur.rs || lcd_data !== cur.data) stab_err++;
        end else if (prev_e) begin
            if (!rst && (lcd_rs !== cur.rs || lcd_data !== cur.data))
                stab_err++;
            pulses.push_back(cur);
        end
        prev_e = lcd_e;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " lcd_e"}, int'(lcd_e), 0);
        check({tag, " lcd_rs"}, int'(lcd_rs), 0);
        check({tag, " lcd_rw"}, int'(lcd_rw), 0);
        check({tag, " lcd_data"}, int'(lcd_data), 0);
        check({tag, " req_ready"}, int'(req_ready), 0);
        check({tag, " init_done"}, int'(init_done), 0);
        check({tag, " busy"}, int'(busy), 1);
    endtask

    // Called at a negedge while in reset; releases and follows init
    task automatic run_init(input string tag);
        int rel;
        bit ok;
        rel = cyc;
        rst = 1'b0;
        early_rdy = 0;
        ok = 1'b0;
        for (int i = 0; i < T_INIT + 50; i++) begin
            @(negedge clk);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " done_lat"}, ok ? cyc - rel : -1, T_INIT);
        check({tag, " ready_with_done"}, int'(req_ready), 1);
        check({tag, " early_ready"}, early_rdy, 0);
        check({tag, " pulses"}, pulses.size(), 4);
        if (pulses.size() > 0)
            check({tag, " first_rise"}, pulses[0].rise - rel, TP + 1 + TS);
        for (int i = 0; i < 4 && i < pulses.size(); i++) begin
            check($sformatf("%s init%0d data", tag, i),
                  int'(pulses[i].data), int'(init_tab[i]));
            check($sformatf("%s init%0d rs", tag, i),
                  int'(pulses[i].rs), 0);
            check($sformatf("%s init%0d width", tag, i),
                  pulses[i].width, TE);
        end
    endtask

    initial begin
        vec_t vt [8];
        int   n0;
        int   acc;
        int   k;
        bit   ok;

        vt[0] = '{1'b1, 8'h41, T_W};
        vt[1] = '{1'b0, 8'h01, T_WC};
        vt[2] = '{1'b0, 8'h80, T_W};
        vt[3] = '{1'b0, 8'h00, T_W};
        vt[4] = '{1'b0, 8'h02, T_WC};
        vt[5] = '{1'b0, 8'h03, T_WC};
        vt[6] = '{1'b0, 8'h04, T_W};
        vt[7] = '{1'b1, 8'h01, T_W};

        repeat (3) @(negedge clk);
        check_reset("rst");
        pulses.delete();
        run_init("init");

        for (int v = 0; v < 8; v++) begin
            wait_ready(100, ok);
            check($sformatf("v%0d idle", v), int'(ok), 1);
            n0 = pulses.size();
            req_rs    = vt[v].rs;
            req_data  = vt[v].data;
            req_valid = 1'b1;
            @(negedge clk);
            acc       = cyc;
            req_valid = 1'b0;
            req_rs    = ~vt[v].rs;
            req_data  = ~vt[v].data;
            wait_ready(100, ok);
            check($sformatf("v%0d latency", v), ok ? cyc - acc : -1, vt[v].lat);
            check($sformatf("v%0d pulses", v), pulses.size() - n0, 1);
            if (pulses.size() == n0 + 1) begin
                check($sformatf("v%0d data", v),
                      int'(pulses[n0].data), int'(vt[v].data));
                check($sformatf("v%0d rs", v),
                      int'(pulses[n0].rs), int'(vt[v].rs));
                check($sformatf("v%0d width", v), pulses[n0].width, TE);
                check($sformatf("v%0d e_delay", v), pulses[n0].rise - acc, TS);
            end
        end

        // Back-to-back with req_valid held and garbage while busy
        wait_ready(100, ok);
        n0 = pulses.size();
        k  = 0;
        ok = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                if (k == 3) begin
                    req_valid = 1'b0;
                    ok = 1'b1;
                    break;
                end
                req_rs   = 1'b1;
                req_data = b2b[k];
                k++;
            end else begin
                req_rs   = 1'($urandom);
                req_data = 8'($urandom);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b done", int'(ok), 1);
        check("b2b pulses", pulses.size() - n0, 3);
        if (pulses.size() == n0 + 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b%0d data", i),
                      int'(pulses[n0 + i].data), int'(b2b[i]));
                check($sformatf("b2b%0d rs", i), int'(pulses[n0 + i].rs), 1);
            end
            check("b2b gap01", pulses[n0 + 1].rise - pulses[n0].rise, T_W + 1);
            check("b2b gap12", pulses[n0 + 2].rise - pulses[n0 + 1].rise, T_W + 1);
        end

        // Reset while E is high, then replay init with an early request
        wait_ready(100, ok);
        req_rs    = 1'b1;
        req_data  = 8'h33;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lcd_e) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid e_seen", int'(ok), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid");
        @(negedge clk);
        pulses.delete();
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        req_valid = 1'b1;
        run_init("replay");
        @(negedge clk);
        req_valid = 1'b0;
        wait_ready(100, ok);
        check("early ready", int'(ok), 1);
        check("early pulses", pulses.size(), 5);
        if (pulses.size() == 5) begin
            check("early data", int'(pulses[4].data), 8'h5A);
            check("early rs", int'(pulses[4].rs), 1);
        end

        repeat (3) @(negedge clk);
        check("early single", pulses.size(), 5);
        check("rw always 0", rw_err, 0);
        check("busy is ~ready", busy_err, 0);
        check("rs/data stable", stab_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
